// File: rtl/video_pkg.sv
// Shared constants and elaboration helpers for the video write path.
package video_pkg;

  localparam int              BURST_CNT_W = 16;
  localparam logic [7:0]      DEF_PAD_VAL = 8'hff;

  function automatic int slot_w(input int pix_w, input int pad_w);
    return pix_w + pad_w;
  endfunction

  function automatic int slots(input int bus_w, input int s_w);
    return bus_w / s_w;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/video_line_packer_if.sv
// Video-in / FIFO-out / burst-request bundle around the line packer.
interface video_line_packer_if
  import video_pkg::*;
#(
  parameter int PIX_W      = 24,
  parameter int BUS_W      = 128,
  parameter int LINE_CNT_W = 12
);
  logic                   video_vs;
  logic                   video_de;
  logic [PIX_W-1:0]       video_data;
  logic [BUS_W-1:0]       fifo_data;
  logic                   fifo_wr_en;
  logic                   burst_valid;
  logic                   burst_ready;
  logic [BURST_CNT_W-1:0] burst_words;
  logic                   frame_start;
  logic                   line_end;
  logic [LINE_CNT_W-1:0]  line_cnt;
  logic                   overflow;

  modport master (
    output video_vs, video_de, video_data, burst_ready,
    input  fifo_data, fifo_wr_en, burst_valid, burst_words,
           frame_start, line_end, line_cnt, overflow
  );

  modport slave (
    input  video_vs, video_de, video_data, burst_ready,
    output fifo_data, fifo_wr_en, burst_valid, burst_words,
           frame_start, line_end, line_cnt, overflow
  );
endinterface

// File: rtl/burst_req_reg.sv
// Single-entry burst request holder; a request arriving while one is stuck is dropped and flagged.
module burst_req_reg
  import video_pkg::*;
(
  input  logic                   video_clk,
  input  logic                   video_rst_n,
  input  logic                   req,
  input  logic [BURST_CNT_W-1:0] req_words,
  input  logic                   clr_ovf,
  input  logic                   burst_ready,
  output logic                   burst_valid,
  output logic [BURST_CNT_W-1:0] burst_words,
  output logic                   overflow
);

  logic can_load;
  assign can_load = !burst_valid || burst_ready;

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      burst_valid <= 1'b0;
      burst_words <= '0;
      overflow    <= 1'b0;
    end else begin
      if (req && can_load) begin
        burst_valid <= 1'b1;
        burst_words <= req_words;
      end else if (burst_valid && burst_ready) begin
        burst_valid <= 1'b0;
      end
      if (clr_ovf)              overflow <= 1'b0;
      else if (req && !can_load) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/video_line_packer.sv
// Packs DE-qualified pixels into FIFO words, flushes partial words at line end,
// and raises burst requests per BURST_LEN words plus a per-line remainder.
module video_line_packer
  import video_pkg::*;
#(
  parameter int               PIX_W      = 24,
  parameter int               PAD_W      = 8,
  parameter logic [PAD_W-1:0] PAD_VAL    = PAD_W'(DEF_PAD_VAL),
  parameter int               BUS_W      = 128,
  parameter int               BURST_LEN  = 16,
  parameter bit               MSB_FIRST  = 1'b1,
  parameter int               LINE_CNT_W = 12
) (
  input  logic         video_clk,
  input  logic         video_rst_n,
  video_line_packer_if.slave vif
);

  localparam int SLOT_W = slot_w(PIX_W, PAD_W);
  localparam int SLOTS  = slots(BUS_W, SLOT_W);
  localparam int SC_W   = clog2(SLOTS);
  localparam logic [SC_W-1:0]        SC_LAST = SC_W'(SLOTS - 1);
  localparam logic [BURST_CNT_W:0]   BL_EXT  = (BURST_CNT_W + 1)'(BURST_LEN);

  logic                   vs_d, de_d;
  logic                   fs_evt, le_evt;
  logic [SC_W-1:0]        slot_cnt, sc_base, slot_sel;
  logic [BUS_W-1:0]       pack_q, pack_base, pack_ins;
  logic [BUS_W-1:0]       fifo_data_q;
  logic                   fifo_wr_q, frame_start_q, line_end_q;
  logic [LINE_CNT_W-1:0]  line_cnt_q;
  logic [BURST_CNT_W-1:0] word_cnt, word_cnt_n, req_words;
  logic [BURST_CNT_W:0]   cnt_n;
  logic                   req;

  assign fs_evt = vif.video_vs && !vs_d;
  assign le_evt = !vif.video_de && de_d;

  // A pixel landing on the frame_start edge belongs to slot 0 of the new frame.
  always_comb begin
    sc_base   = fs_evt ? '0 : slot_cnt;
    pack_base = fs_evt ? '0 : pack_q;
    slot_sel  = MSB_FIRST ? (SC_LAST - sc_base) : sc_base;
    pack_ins  = pack_base;
    for (int s = 0; s < SLOTS; s++)
      if (SC_W'(s) == slot_sel)
        pack_ins[s*SLOT_W +: SLOT_W] = {PAD_VAL, vif.video_data};
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      vs_d          <= 1'b0;
      de_d          <= 1'b0;
      slot_cnt      <= '0;
      pack_q        <= '0;
      fifo_data_q   <= '0;
      fifo_wr_q     <= 1'b0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      line_cnt_q    <= '0;
    end else begin
      vs_d          <= vif.video_vs;
      de_d          <= vif.video_de;
      frame_start_q <= fs_evt;
      line_end_q    <= le_evt;
      fifo_wr_q     <= 1'b0;
      if (fs_evt)      line_cnt_q <= '0;
      else if (le_evt) line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);

      if (vif.video_de) begin
        if (sc_base == SC_LAST) begin
          fifo_data_q <= pack_ins;
          fifo_wr_q   <= 1'b1;
          pack_q      <= '0;
          slot_cnt    <= '0;
        end else begin
          pack_q   <= pack_ins;
          slot_cnt <= sc_base + SC_W'(1);
        end
      end else if (fs_evt) begin
        pack_q   <= '0;
        slot_cnt <= '0;
      end else if (le_evt && slot_cnt != '0) begin
        // pack_q already holds zeros in the unused slots
        fifo_data_q <= pack_q;
        fifo_wr_q   <= 1'b1;
        pack_q      <= '0;
        slot_cnt    <= '0;
      end
    end
  end

  // A word that completes a burst on the line-end cycle yields one full request, not a remainder.
  always_comb begin
    cnt_n      = {1'b0, word_cnt} + (BURST_CNT_W + 1)'(fifo_wr_q);
    word_cnt_n = cnt_n[BURST_CNT_W-1:0];
    req        = 1'b0;
    req_words  = '0;
    if (fs_evt) begin
      word_cnt_n = '0;
    end else if (cnt_n == BL_EXT) begin
      req        = 1'b1;
      req_words  = BURST_CNT_W'(BURST_LEN);
      word_cnt_n = '0;
    end else if (line_end_q && cnt_n != '0) begin
      req        = 1'b1;
      req_words  = cnt_n[BURST_CNT_W-1:0];
      word_cnt_n = '0;
    end
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) word_cnt <= '0;
    else              word_cnt <= word_cnt_n;
  end

  burst_req_reg u_req (
    .video_clk   (video_clk),
    .video_rst_n (video_rst_n),
    .req         (req),
    .req_words   (req_words),
    .clr_ovf     (fs_evt),
    .burst_ready (vif.burst_ready),
    .burst_valid (vif.burst_valid),
    .burst_words (vif.burst_words),
    .overflow    (vif.overflow)
  );

  assign vif.fifo_data   = fifo_data_q;
  assign vif.fifo_wr_en  = fifo_wr_q;
  assign vif.frame_start = frame_start_q;
  assign vif.line_end    = line_end_q;
  assign vif.line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_video_line_packer.sv
// Directed bench: MSB_FIRST and LSB_FIRST packers (BURST_LEN=4) driven with identical stimulus.
module tb_video_line_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, de, ready;
  logic [23:0] data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  video_line_packer_if #(.PIX_W(24), .BUS_W(128), .LINE_CNT_W(12)) ia ();
  video_line_packer_if #(.PIX_W(24), .BUS_W(128), .LINE_CNT_W(12)) ib ();

  assign ia.video_vs = vs;  assign ia.video_de = de;
  assign ia.video_data = data; assign ia.burst_ready = ready;
  assign ib.video_vs = vs;  assign ib.video_de = de;
  assign ib.video_data = data; assign ib.burst_ready = ready;

  video_line_packer #(.BURST_LEN(4), .MSB_FIRST(1'b1)) u_msb (
    .video_clk(clk), .video_rst_n(rst_n), .vif(ia));
  video_line_packer #(.BURST_LEN(4), .MSB_FIRST(1'b0)) u_lsb (
    .video_clk(clk), .video_rst_n(rst_n), .vif(ib));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [23:0] d);
    de = 1'b1; data = d;
    tick();
  endtask

  task automatic all_zero(input string tag);
    check({tag, ".data"},  ia.fifo_data,   '0);
    check({tag, ".wr"},    ia.fifo_wr_en,  '0);
    check({tag, ".bv"},    ia.burst_valid, '0);
    check({tag, ".bw"},    ia.burst_words, '0);
    check({tag, ".fs"},    ia.frame_start, '0);
    check({tag, ".le"},    ia.line_end,    '0);
    check({tag, ".lc"},    ia.line_cnt,    '0);
    check({tag, ".ovf"},   ia.overflow,    '0);
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; de = 1'b0; ready = 1'b1; data = '0;
    tick(); tick();
    all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 16-pixel line -> 4 words, one full request after the 4th write
    for (int i = 1; i <= 16; i++) begin
      pix(24'(i));
      if (i == 4) begin
        check("l16.w0.wr",   ia.fifo_wr_en, 1'b1);
        check("l16.w0.msb",  ia.fifo_data, 128'hff000001_ff000002_ff000003_ff000004);
        check("l16.w0.lsb",  ib.fifo_data, 128'hff000004_ff000003_ff000002_ff000001);
      end
      if (i == 5) check("l16.nobv", ia.burst_valid, 1'b0);
      if (i == 8) check("l16.w1.lsb", ib.fifo_data, 128'hff000008_ff000007_ff000006_ff000005);
    end
    check("l16.w3.msb", ia.fifo_data, 128'hff00000d_ff00000e_ff00000f_ff000010);
    de = 1'b0; tick();
    check("l16.le",    ia.line_end,    1'b1);
    check("l16.lc",    ia.line_cnt,    12'd1);
    check("l16.bv",    ia.burst_valid, 1'b1);
    check("l16.bw",    ia.burst_words, 16'd4);
    check("l16.wr0",   ia.fifo_wr_en,  1'b0);
    tick();
    check("l16.norem", ia.burst_valid, 1'b0);
    check("l16.le0",   ia.line_end,    1'b0);

    // 6-pixel line -> full word + padded partial flush + remainder of 2
    for (int i = 1; i <= 6; i++) pix(24'(i));
    de = 1'b0; tick();
    check("l6.le",    ia.line_end,   1'b1);
    check("l6.wr",    ia.fifo_wr_en, 1'b1);
    check("l6.flush", ia.fifo_data,  128'hff000005_ff000006_00000000_00000000);
    check("l6.lc",    ia.line_cnt,   12'd2);
    tick();
    check("l6.bv",    ia.burst_valid, 1'b1);
    check("l6.bw",    ia.burst_words, 16'd2);
    tick();
    check("l6.bv0",   ia.burst_valid, 1'b0);

    // Ready held low: first request held, second dropped
    ready = 1'b0;
    for (int i = 1; i <= 16; i++) pix(24'(i));
    de = 1'b0; tick();
    check("ovf.bv1",  ia.burst_valid, 1'b1);
    check("ovf.ov0",  ia.overflow,    1'b0);
    tick();
    for (int i = 17; i <= 32; i++) pix(24'(i));
    de = 1'b0; tick();
    check("ovf.ov1",  ia.overflow,    1'b1);
    check("ovf.bw",   ia.burst_words, 16'd4);
    check("ovf.lc",   ia.line_cnt,    12'd4);
    vs = 1'b1; tick();
    check("fs.pulse", ia.frame_start, 1'b1);
    check("fs.ovf",   ia.overflow,    1'b0);
    check("fs.lc",    ia.line_cnt,    12'd0);
    check("fs.bv",    ia.burst_valid, 1'b1);
    vs = 1'b0; tick();
    check("fs.pulse0", ia.frame_start, 1'b0);
    ready = 1'b1; tick();
    check("fs.drain", ia.burst_valid, 1'b0);

    // Handshake in the same cycle a new request is generated
    ready = 1'b0;
    for (int i = 1; i <= 16; i++) pix(24'(i));
    de = 1'b0; tick();
    check("hs.bv", ia.burst_valid, 1'b1);
    tick();
    for (int i = 1; i <= 6; i++) pix(24'(i));
    de = 1'b0; tick();
    ready = 1'b1; tick();
    check("hs.bv1",  ia.burst_valid, 1'b1);
    check("hs.bw",   ia.burst_words, 16'd2);
    check("hs.ovf",  ia.overflow,    1'b0);
    tick();
    check("hs.bv0",  ia.burst_valid, 1'b0);

    // Reset mid-line discards the partial word
    for (int i = 1; i <= 3; i++) pix(24'(i));
    check("rst.lc_pre", ia.line_cnt, 12'd2);
    de = 1'b0;
    #2 rst_n = 1'b0;
    #1 all_zero("midrst");
    tick();
    check("midrst.noflush", ia.fifo_wr_en, 1'b0);
    rst_n = 1'b1;
    tick();
    pix(24'ha); pix(24'hb); pix(24'hc); pix(24'hd);
    check("post.wr",   ia.fifo_wr_en, 1'b1);
    check("post.data", ia.fifo_data,  128'hff00000a_ff00000b_ff00000c_ff00000d);
    de = 1'b0; tick();
    check("post.le",   ia.line_end,   1'b1);
    check("post.wr0",  ia.fifo_wr_en, 1'b0);
    check("post.lc",   ia.line_cnt,   12'd1);
    tick();
    check("post.bv",   ia.burst_valid, 1'b1);
    check("post.bw",   ia.burst_words, 16'd1);
    tick();
    check("post.bv0",  ia.burst_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
